branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 13 +
 rtl/branch_predictor_sat_ctr2.sv | 21 ++
 rtl/branch_predictor.sv | 135 +++++++++++++
 tb/tb_branch_predictor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared core definitions for the branch predictor: counter encodings and default width.
package branch_predictor_pkg;

  localparam int unsigned DEF_XLEN = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Combinational next state of a 2-bit saturating taken/not-taken counter.
module sat_ctr2
  import branch_predictor_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic tkn_i,
  output ctr_e ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (ctr_i)
      SNT:     ctr_o = tkn_i ? WNT : SNT;
      WNT:     ctr_o = tkn_i ? WT  : SNT;
      WT:      ctr_o = tkn_i ? ST  : WNT;
      ST:      ctr_o = tkn_i ? ST  : WT;
      default: ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: one registered lookup and one update per cycle.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN    = DEF_XLEN,
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_vld,
  input  logic [XLEN-1:0] req_pc,
  output logic            pred_vld,
  output logic            pred_tkn,
  output logic [XLEN-1:0] pred_tgt,
  input  logic            upd_vld,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_br,
  input  logic            upd_is_jmp,
  input  logic            upd_tkn,
  input  logic [XLEN-1:0] upd_tgt
);

  localparam int unsigned IDXW = $clog2(ENTRIES);
  localparam int unsigned TAGW = XLEN - IDXW - 2;

  logic            valid_q [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0] tgt_q   [ENTRIES];
  logic            jmp_q   [ENTRIES];
  ctr_e            ctr_q   [ENTRIES];

  logic            pred_vld_q, pred_vld_d;
  logic            pred_tkn_q, pred_tkn_d;
  logic [XLEN-1:0] pred_tgt_q, pred_tgt_d;

  logic [IDXW-1:0] req_idx;
  logic [TAGW-1:0] req_tag;
  logic            req_hit;
  logic            req_tkn;

  logic [IDXW-1:0] upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_en;
  logic            upd_hit;
  logic            wr_en;
  ctr_e            ctr_next;
  ctr_e            new_ctr;
  logic            new_jmp;
  logic [XLEN-1:0] new_tgt;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_ok;
  assign unused_ok = ^{req_pc[1:0], upd_pc[1:0]};

  assign req_idx = req_pc[IDXW+1:2];
  assign req_tag = req_pc[XLEN-1:IDXW+2];
  assign upd_idx = upd_pc[IDXW+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDXW+2];

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  always_comb begin
    req_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    req_tkn    = req_hit && (jmp_q[req_idx] || (ctr_q[req_idx] == WT) || (ctr_q[req_idx] == ST));
    pred_vld_d = req_vld;
    pred_tkn_d = req_vld && req_tkn;
    pred_tgt_d = req_tkn ? tgt_q[req_idx] : XLEN'(req_pc + XLEN'(4));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_vld_q <= 1'b0;
      pred_tkn_q <= 1'b0;
      pred_tgt_q <= '0;
    end else begin
      pred_vld_q <= pred_vld_d;
      pred_tkn_q <= pred_tkn_d;
      pred_tgt_q <= pred_tgt_d;
    end
  end

  assign pred_vld = pred_vld_q;
  assign pred_tkn = pred_tkn_q;
  assign pred_tgt = pred_tgt_q;

  sat_ctr2 u_ctr (
    .ctr_i (ctr_q[upd_idx]),
    .tkn_i (upd_tkn),
    .ctr_o (ctr_next)
  );

  // Jumps win over branches; a jump-flagged entry is pinned at strongly taken.
  always_comb begin
    upd_en  = upd_vld && (upd_is_br || upd_is_jmp);
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    wr_en   = upd_en && (upd_hit || upd_tkn);
    new_tgt = tgt_q[upd_idx];
    new_jmp = jmp_q[upd_idx];
    new_ctr = ctr_next;
    if (!upd_hit) begin
      new_tgt = upd_tgt;
      new_jmp = upd_is_jmp;
      new_ctr = upd_is_jmp ? ST : WT;
    end else begin
      if (upd_tkn) begin
        new_tgt = upd_tgt;
        new_jmp = upd_is_jmp;
      end
      if (new_jmp) begin
        new_ctr = ST;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else if (wr_en) begin
      valid_q[upd_idx] <= 1'b1;
      ctr_q[upd_idx]   <= new_ctr;
    end
  end

  // Payload fields are only observed behind a set valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= new_tgt;
      jmp_q[upd_idx] <= new_jmp;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios plus random traffic against a table-level model.
module tb_branch_predictor;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDXW    = $clog2(ENTRIES);

  logic            clk = 1'b0;
  logic            rst;
  logic            req_vld;
  logic [XLEN-1:0] req_pc;
  logic            pred_vld;
  logic            pred_tkn;
  logic [XLEN-1:0] pred_tgt;
  logic            upd_vld;
  logic [XLEN-1:0] upd_pc;
  logic            upd_is_br;
  logic            upd_is_jmp;
  logic            upd_tkn;
  logic [XLEN-1:0] upd_tgt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain per-index records, counter as an integer 0..3.
  bit              m_valid [ENTRIES];
  logic [XLEN-1:0] m_pc    [ENTRIES];
  logic [XLEN-1:0] m_tgt   [ENTRIES];
  bit              m_jmp   [ENTRIES];
  int              m_ctr   [ENTRIES];

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_pc     (req_pc),
    .pred_vld   (pred_vld),
    .pred_tkn   (pred_tkn),
    .pred_tgt   (pred_tgt),
    .upd_vld    (upd_vld),
    .upd_pc     (upd_pc),
    .upd_is_br  (upd_is_br),
    .upd_is_jmp (upd_is_jmp),
    .upd_tkn    (upd_tkn),
    .upd_tgt    (upd_tgt)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [XLEN-1:0] pc);
    int i = m_idx(pc);
    return m_valid[i] && ((m_pc[i] >> (IDXW + 2)) == (pc >> (IDXW + 2)));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic m_update(input bit v, input logic [XLEN-1:0] pc, input bit br, input bit jmp,
                          input bit tkn, input logic [XLEN-1:0] tgt);
    int i = m_idx(pc);
    if (!v || !(br || jmp)) return;
    if (!m_hit(pc)) begin
      if (tkn) begin
        m_valid[i] = 1'b1;
        m_pc[i]    = pc;
        m_tgt[i]   = tgt;
        m_jmp[i]   = jmp;
        m_ctr[i]   = jmp ? 3 : 2;
      end
    end else begin
      if (tkn) begin
        m_tgt[i] = tgt;
        m_jmp[i] = jmp;
        m_pc[i]  = pc;
      end
      if (m_jmp[i])  m_ctr[i] = 3;
      else if (tkn)  m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
      else           m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
    end
  endtask

  // One cycle of lookup + update; prediction expected from the table as it was before the update.
  task automatic step(input bit rv, input logic [XLEN-1:0] rpc, input bit uv, input logic [XLEN-1:0] upc,
                      input bit ubr, input bit ujmp, input bit utkn, input logic [XLEN-1:0] utgt);
    bit              e_tkn;
    logic [XLEN-1:0] e_tgt;
    int              i;
    req_vld = rv; req_pc = rpc;
    upd_vld = uv; upd_pc = upc; upd_is_br = ubr; upd_is_jmp = ujmp; upd_tkn = utkn; upd_tgt = utgt;
    i = m_idx(rpc);
    e_tkn = m_hit(rpc) && (m_jmp[i] || m_ctr[i] >= 2);
    e_tgt = e_tkn ? m_tgt[i] : rpc + 32'd4;
    m_update(uv, upc, ubr, ujmp, utkn, utgt);
    @(posedge clk);
    #1;
    chk("pred_vld", {31'd0, pred_vld}, {31'd0, rv});
    if (rv) begin
      chk("pred_tkn", {31'd0, pred_tkn}, {31'd0, e_tkn});
      chk("pred_tgt", pred_tgt, e_tgt);
    end
  endtask

  task automatic look(input logic [XLEN-1:0] pc);
    step(1'b1, pc, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic upd(input logic [XLEN-1:0] pc, input bit br, input bit jmp, input bit tkn,
                     input logic [XLEN-1:0] tgt);
    step(1'b0, '0, 1'b1, pc, br, jmp, tkn, tgt);
  endtask

  initial begin
    logic [XLEN-1:0] rpc, upc;
    rst = 1'b1;
    req_vld = 1'b0; req_pc = '0;
    upd_vld = 1'b0; upd_pc = '0; upd_is_br = 1'b0; upd_is_jmp = 1'b0; upd_tkn = 1'b0; upd_tgt = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", {31'd0, pred_vld}, 32'd0);
    chk("rst_tkn", {31'd0, pred_tkn}, 32'd0);
    chk("rst_tgt", pred_tgt, 32'd0);
    rst = 1'b0;
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);

    // Cold lookup and branch training
    look(32'h100);
    chk("cold_tkn", {31'd0, pred_tkn}, 32'd0);
    chk("cold_tgt", pred_tgt, 32'h104);
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80);
    look(32'h100);
    chk("train_tkn", {31'd0, pred_tkn}, 32'd1);
    chk("train_tgt", pred_tgt, 32'h80);
    upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
    look(32'h100);
    chk("untrain_tkn", {31'd0, pred_tkn}, 32'd0);
    chk("untrain_tgt", pred_tgt, 32'h104);

    // Saturation at 0x200
    repeat (5) upd(32'h200, 1'b1, 1'b0, 1'b1, 32'h280);
    upd(32'h200, 1'b1, 1'b0, 1'b0, 32'h0);
    look(32'h200);
    chk("sat_hi_tkn", {31'd0, pred_tkn}, 32'd1);
    repeat (3) upd(32'h200, 1'b1, 1'b0, 1'b0, 32'h0);
    look(32'h200);
    chk("sat_lo_tkn", {31'd0, pred_tkn}, 32'd0);

    // Ignored update without branch/jump flags
    upd(32'h20, 1'b0, 1'b0, 1'b1, 32'h999);
    look(32'h20);
    chk("nobr_tkn", {31'd0, pred_tkn}, 32'd0);

    // Jump then aliasing branch
    upd(32'h40, 1'b0, 1'b1, 1'b1, 32'h400);
    look(32'h40);
    chk("jmp_tgt", pred_tgt, 32'h400);
    upd(32'h40 + 4 * ENTRIES, 1'b1, 1'b0, 1'b1, 32'h10);
    look(32'h40);
    chk("alias_miss_tkn", {31'd0, pred_tkn}, 32'd0);
    chk("alias_miss_tgt", pred_tgt, 32'h44);
    look(32'h40 + 4 * ENTRIES);
    chk("alias_hit_tgt", pred_tgt, 32'h10);

    // Same-cycle lookup and update
    step(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 32'h3c0);
    chk("rbw_first", {31'd0, pred_tkn}, 32'd0);
    look(32'h300);
    chk("rbw_next", {31'd0, pred_tkn}, 32'd1);

    // PC+4 wrap
    look(32'hffff_fffc);
    chk("wrap_tgt", pred_tgt, 32'h0);

    // Async reset mid-stream with a lookup in flight
    look(32'h300);
    chk("pre_rst_tkn", {31'd0, pred_tkn}, 32'd1);
    req_vld = 1'b1; req_pc = 32'h300; upd_vld = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst_vld", {31'd0, pred_vld}, 32'd0);
    chk("arst_tkn", {31'd0, pred_tkn}, 32'd0);
    chk("arst_tgt", pred_tgt, 32'd0);
    m_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("post_rst_vld", {31'd0, pred_vld}, 32'd0);
    look(32'h300);
    chk("post_rst_tkn", {31'd0, pred_tkn}, 32'd0);

    // Random traffic on a small PC footprint so hits and aliases are frequent
    for (int n = 0; n < 600; n++) begin
      rpc = ($urandom_range(0, 3) << (IDXW + 2)) | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
      upc = ($urandom_range(0, 3) << (IDXW + 2)) | ($urandom_range(0, ENTRIES - 1) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) upc = rpc;
      step($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 1) == 1, upc,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
           32'($urandom) & 32'hffff_fffc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
